// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared FSM state type and scan-code constants for the PS/2 keyboard receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_e;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam int         DATA_BITS  = 8;

  // True when data byte plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - 2-FF synchronizers, PS/2 clock glitch filter and falling-edge detect
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall_edge
);

  logic [1:0]            clk_sync_q, clk_sync_d;
  logic [1:0]            data_sync_q, data_sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  filt_q, filt_d;
  logic                  filt_prev_q, filt_prev_d;

  // The filtered level flips only once the whole sample window agrees.
  always_comb begin
    clk_sync_d  = {clk_sync_q[0], ps2_clk};
    data_sync_d = {data_sync_q[0], ps2_data};
    hist_d      = {hist_q[FILTER_LEN-2:0], clk_sync_q[1]};
    filt_prev_d = filt_q;
    filt_d      = filt_q;
    if (&hist_d) begin
      filt_d = 1'b1;
    end else if (~|hist_d) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      hist_q      <= '1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      hist_q      <= hist_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
    end
  end

  assign data_sync = data_sync_q[1];
  assign fall_edge = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_keyboard.sv
// rtl/ps2_keyboard.sv - PS/2 keyboard frame receiver and make/break decoder; PS2_PARITY_CHECK_EN enables odd-parity checking
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_pressed,
  output logic       key_released,
  output logic [7:0] last_pressed,
  output logic       extended,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    LAST_BIT     = 3'(DATA_BITS - 1);

  logic data_sync, fall_edge, byte_ok;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ext_pend_q, ext_pend_d;
  logic          brk_pend_q, brk_pend_d;
  logic          pressed_q, pressed_d;
  logic          released_q, released_d;
  logic          err_q, err_d;
  logic [7:0]    last_q, last_d;
  logic          ext_q, ext_d;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data_sync),
    .fall_edge (fall_edge)
  );

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  assign byte_ok = data_sync & odd_parity_ok(shift_q, par_q);
`else
  assign byte_ok = data_sync;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    timer_d    = '0;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    err_d      = 1'b0;
    last_d     = last_q;
    ext_d      = ext_q;
`ifdef PS2_PARITY_CHECK_EN
    par_d      = par_q;
`endif
    if (state_q != ST_IDLE && !fall_edge) begin
      timer_d = timer_q + TW'(1);
    end
    case (state_q)
      ST_IDLE: begin
        if (fall_edge && !data_sync) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      ST_DATA: begin
        if (fall_edge) begin
          shift_d   = {data_sync, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall_edge) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = data_sync;
`endif
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_edge) begin
          state_d = ST_IDLE;
          if (!byte_ok) begin
            err_d = 1'b1;
          end else if (shift_q == EXT_CODE) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == BREAK_CODE) begin
            brk_pend_d = 1'b1;
          end else if (brk_pend_q) begin
            released_d = 1'b1;
            brk_pend_d = 1'b0;
            ext_pend_d = 1'b0;
          end else begin
            pressed_d  = 1'b1;
            last_d     = shift_q;
            ext_d      = ext_pend_q;
            ext_pend_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A stalled frame is dropped silently; decoder state and outputs are untouched.
    if (state_q != ST_IDLE && !fall_edge && timer_q == TIMEOUT_LAST) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      timer_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      timer_q    <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      err_q      <= 1'b0;
      last_q     <= '0;
      ext_q      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      timer_q    <= timer_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      err_q      <= err_d;
      last_q     <= last_d;
      ext_q      <= ext_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign key_pressed  = pressed_q;
  assign key_released = released_q;
  assign frame_err    = err_q;
  assign last_pressed = last_q;
  assign extended     = ext_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb/tb_ps2_keyboard.sv - scoreboard bench for ps2_keyboard; expectations follow PS2_PARITY_CHECK_EN
module tb_ps2_keyboard;

  localparam int FL = 8;
  localparam int TO = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_pressed, key_released, frame_err, extended;
  logic [7:0] last_pressed;

  always #5 clk = ~clk;

  ps2_keyboard #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_pressed  (key_pressed),
    .key_released (key_released),
    .last_pressed (last_pressed),
    .extended     (extended),
    .frame_err    (frame_err)
  );

  typedef enum {EV_PRESS, EV_REL, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e   kind;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  logic prev_pulse = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [7:0] c, input logic e);
    ev_t ev;
    ev.kind = k;
    ev.code = c;
    ev.ext  = e;
    exp_q.push_back(ev);
  endtask

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    logic [2:0] p;
    logic [2:0] want;
    ev_t        ev;
    p = {key_pressed, key_released, frame_err};
    if (rst_n && p != 3'b000) begin
      check("pulse_not_back_to_back", {31'd0, prev_pulse}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got pulses %b expected none", p);
      end else begin
        ev = exp_q.pop_front();
        want = (ev.kind == EV_PRESS) ? 3'b100 : (ev.kind == EV_REL) ? 3'b010 : 3'b001;
        check("pulse_kind", {29'd0, p}, {29'd0, want});
        if (ev.kind != EV_ERR) begin
          check("last_pressed", {24'd0, last_pressed}, {24'd0, ev.code});
        end
        if (ev.kind == EV_PRESS) begin
          check("extended", {31'd0, extended}, {31'd0, ev.ext});
        end
      end
    end
    prev_pulse = |p;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    wait_cyc(20);
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(4);
      ps2_clk = 1'b0;
      wait_cyc(FL - 2);
      ps2_clk = 1'b1;
      wait_cyc(4);
    end else begin
      wait_cyc(10);
    end
  endtask

  // Sends frame bits [first, first+n): start, 8 data LSB first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int first, input int n, input int glitch_bit);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = first; i < first + n; i++) begin
      ps2_bit(f[i], i == glitch_bit);
    end
    ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, ~^b, 1'b1, 0, 11, -1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_key_pressed"}, {31'd0, key_pressed}, 32'd0);
    check({tag, "_key_released"}, {31'd0, key_released}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    check({tag, "_last_pressed"}, {24'd0, last_pressed}, 32'd0);
    check({tag, "_extended"}, {31'd0, extended}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wait_cyc(5);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    wait_cyc(20);

    push(EV_PRESS, 8'h1C, 1'b0);
    send_good(8'h1C);

    push(EV_PRESS, 8'h75, 1'b1);
    send_good(8'hE0);
    send_good(8'h75);

    push(EV_PRESS, 8'h1C, 1'b0);
    push(EV_REL, 8'h1C, 1'b0);
    send_good(8'h1C);
    send_good(8'hF0);
    send_good(8'h1C);

    push(EV_PRESS, 8'h1C, 1'b0);
    push(EV_PRESS, 8'h1C, 1'b0);
    send_good(8'h1C);
    send_good(8'h1C);

    push(EV_REL, 8'h1C, 1'b0);
    push(EV_PRESS, 8'h29, 1'b0);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    send_good(8'h29);

`ifdef PS2_PARITY_CHECK_EN
    push(EV_ERR, 8'h00, 1'b0);
`else
    push(EV_PRESS, 8'h1C, 1'b0);
`endif
    send_frame(8'h1C, 1'b1, 1'b1, 0, 11, -1);

    push(EV_ERR, 8'h00, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0, 0, 11, -1);

    send_frame(8'h55, 1'b1, 1'b1, 0, 5, -1);
    wait_cyc(TO + 20);
    push(EV_PRESS, 8'h6B, 1'b0);
    send_good(8'h6B);

    push(EV_PRESS, 8'h5A, 1'b0);
    send_frame(8'h5A, ~^8'h5A, 1'b1, 0, 11, 3);

    send_frame(8'hF3, 1'b1, 1'b1, 0, 5, -1);
    rst_n = 1'b0;
    wait_cyc(3);
    check_outputs_zero("midframe_reset");
    rst_n = 1'b1;
    wait_cyc(5);
    send_frame(8'hF3, 1'b1, 1'b1, 5, 6, -1);
    push(EV_PRESS, 8'h1C, 1'b0);
    send_good(8'h1C);

    wait_cyc(50);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
- REQ-001 The module SHALL have parameter FILTER_LEN, default 8: the number of consecutive equal samples required before the filtered PS/2 clock changes level.
- REQ-002 The module SHALL have parameter TIMEOUT_CYCLES, default 10000: the number of clk cycles without a falling edge, mid-frame, that aborts the frame.
- REQ-003 clk  input  1  system clock; the only clock in the block.
- REQ-004 rst_n  input  1  reset; synchronous, active-low.
- REQ-005 ps2_clk  input  1  PS/2 clock line; asynchronous to clk; idles high.
- REQ-006 ps2_data  input  1  PS/2 data line; asynchronous to clk; idles high.
- REQ-007 key_pressed  output  1  one-cycle pulse on each accepted make code.
- REQ-008 key_released  output  1  one-cycle pulse on each accepted break code.
- REQ-009 last_pressed  output  8  most recent make code; held between make codes.
- REQ-010 extended  output  1  set when the most recent make code was E0-prefixed.
- REQ-011 frame_err  output  1  one-cycle pulse on a rejected frame.

Function
- REQ-012 ps2_clk and ps2_data SHALL pass through a 2-FF synchronizer each.
- REQ-013 The filtered clock SHALL change level only after FILTER_LEN consecutive equal synchronized samples.
- REQ-014 One bit SHALL be sampled from synchronized ps2_data in the clk cycle the filtered clock's high-to-low edge is detected.
- REQ-015 Frame format SHALL be: start bit 0, 8 data bits LSB first, odd parity bit, stop bit 1.
- REQ-016 FSM states SHALL be IDLE, DATA, PARITY, STOP.
  - IDLE -> DATA on an edge with data=0; a start bit of 1 is ignored and the FSM stays in IDLE.
  - DATA -> PARITY after 8 bits.
  - PARITY -> STOP after one edge.
  - STOP -> IDLE after one edge.
- REQ-017 The byte SHALL be accepted when stop=1 and parity is odd. Otherwise the byte SHALL be discarded and frame_err pulsed.
- REQ-018 In any state other than IDLE, TIMEOUT_CYCLES cycles without an edge SHALL return the FSM to IDLE, discard the partial byte and leave all outputs unchanged.
- REQ-019 Accepted byte 0xE0 SHALL set ext_pending. Accepted byte 0xF0 SHALL set brk_pending. Neither byte SHALL pulse any output.
- REQ-020 Any other accepted byte with brk_pending set SHALL pulse key_released and clear both pending flags. last_pressed and extended SHALL be unchanged.
- REQ-021 Any other accepted byte with brk_pending clear SHALL load last_pressed with the byte and extended with ext_pending, pulse key_pressed, and clear ext_pending.
- REQ-022 Outputs SHALL update on the clk edge following the cycle in which the stop-bit edge is detected (latency 1 cycle).
- REQ-023 Typematic repeats of a make code SHALL each produce a key_pressed pulse.
- REQ-024 key_pressed, key_released and frame_err SHALL be mutually exclusive and never high two consecutive cycles.

Reset
- REQ-025 While rst_n=0 at a clk edge, the following SHALL hold:
  - FSM in IDLE;
  - bit counter, shift register and pending flags = 0;
  - synchronizer and filter registers = 1;
  - all outputs = 0.
- REQ-026 Reset asserted mid-frame SHALL discard the frame. Reception after release SHALL begin only at the next start bit.

Configuration
- REQ-027 Macro PS2_PARITY_CHECK_EN:
  - Defined: parity SHALL be checked per REQ-017.
  - Undefined: the parity bit SHALL be sampled and ignored, and only the stop bit SHALL decide acceptance.

Structure
- REQ-028 Package ps2_pkg SHALL hold the FSM state enum and the constants BREAK_CODE=8'hF0, EXT_CODE=8'hE0 and DATA_BITS=8.
- REQ-029 Synchronizer, filter and falling-edge detect SHALL form sub-module ps2_clk_filter, parameterized by FILTER_LEN.

Verification
- REQ-030 Frame 0x1C with parity 0 -> one key_pressed pulse; last_pressed=0x1C; extended=0.
- REQ-031 Frames E0 then 75 -> exactly one key_pressed pulse; last_pressed=0x75; extended=1.
- REQ-032 Make 1C, then F0, then 1C -> one key_pressed pulse, then one key_released pulse; last_pressed stays 0x1C.
- REQ-033 Frame 0x1C with parity bit 1:
  - macro defined -> frame_err pulse, no key_pressed;
  - macro undefined -> key_pressed pulse with last_pressed=0x1C.
- REQ-034 Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES+1 cycles, then a valid 0x6B frame -> no pulse during the abort; last_pressed=0x6B afterwards.
- REQ-035 Two glitch/reset cases:
  - a ps2_clk low glitch of FILTER_LEN-2 cycles mid-frame -> no bit sampled, and the frame decodes correctly;
  - rst_n=0 mid-frame -> all outputs 0 and no pulse from the remainder of that frame.
